// File: rtl/sprite_scan_pkg.sv
// Shared types and field layout for the multi-sprite pattern address scanner.
package sprite_scan_pkg;

  localparam int SCAN_COORD_W = 10;
  localparam int SCAN_ADDR_W  = 16;

  // Per-sprite descriptor widths inside the flat sprite_info / pattern_info buses.
  localparam int SPR_W = 3 + 3 * SCAN_COORD_W;
  localparam int PAT_W = SCAN_ADDR_W + 8 + 2 * SCAN_COORD_W;

  // Bit offsets of each field within one sprite descriptor (LSB positions).
  localparam int SPR_SHIFT_LSB   = 0;
  localparam int SPR_Y_LSB       = SCAN_COORD_W;
  localparam int SPR_X_LSB       = 2 * SCAN_COORD_W;
  localparam int SPR_VFLIP_BIT   = 3 * SCAN_COORD_W;
  localparam int SPR_HFLIP_BIT   = 3 * SCAN_COORD_W + 1;
  localparam int SPR_VISIBLE_BIT = 3 * SCAN_COORD_W + 2;

  // Bit offsets of each field within one pattern descriptor (LSB positions).
  localparam int PAT_ACT_V_LSB  = 0;
  localparam int PAT_ACT_H_LSB  = SCAN_COORD_W;
  localparam int PAT_LOG2_V_LSB = 2 * SCAN_COORD_W;
  localparam int PAT_LOG2_H_LSB = 2 * SCAN_COORD_W + 4;
  localparam int PAT_APPEND_LSB = 2 * SCAN_COORD_W + 8;

  typedef struct packed {
    logic                    visible;
    logic                    hflip;
    logic                    vflip;
    logic [SCAN_COORD_W-1:0] x;
    logic [SCAN_COORD_W-1:0] y;
    logic [SCAN_COORD_W-1:0] shift;
  } sprite_t;

  typedef struct packed {
    logic [SCAN_ADDR_W-1:0]  append;
    logic [3:0]              log2_res_h;
    logic [3:0]              log2_res_v;
    logic [SCAN_COORD_W-1:0] act_h;
    logic [SCAN_COORD_W-1:0] act_v;
  } pattern_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } scan_state_t;

  // Tile sizes above 256 pixels are not supported; larger log2 values saturate.
  function automatic logic [3:0] clamp_log2(input logic [3:0] v);
    return (v > 4'd8) ? 4'd8 : v;
  endfunction

endpackage

// File: rtl/sprite_hit_eval.sv
// Combinational hit test and pattern address for one sprite at one pixel.
module sprite_hit_eval
  import sprite_scan_pkg::*;
(
  input  sprite_t                 spr_i,
  input  pattern_t                pat_i,
  input  logic [SCAN_COORD_W-1:0] hcount_i,
  input  logic [SCAN_COORD_W-1:0] vcount_i,
  output logic                    hit_o,
  output logic [SCAN_ADDR_W-1:0]  addr_o
);

  // Two guard bits so x+act_h and y+act_v never wrap.
  localparam int EW = SCAN_COORD_W + 2;
  typedef logic [EW-1:0] ext_t;

  ext_t       hc, vc, x, y, sh, ah, av;
  ext_t       mask_h, mask_v, rx, ry;
  logic [3:0] lh, lv;
  logic       h_in, v_in;

  // Range test, tile-local coordinates with optional flip, then address sum.
  always_comb begin
    // NOTE: every output of this block is assigned on every path before any
    // conditional override, so no latch can be inferred.
    hc = {2'b00, hcount_i};
    vc = {2'b00, vcount_i};
    x  = {2'b00, spr_i.x};
    y  = {2'b00, spr_i.y};
    sh = {2'b00, spr_i.shift};
    ah = {2'b00, pat_i.act_h};
    av = {2'b00, pat_i.act_v};

    v_in  = (vc >= y) && (vc < y + av);
    // act_h <= shift leaves an empty span; guard it before the subtraction.
    h_in  = (ah > sh) && (hc >= x) && (hc < x + ah - sh);
    hit_o = spr_i.visible && v_in && h_in;

    lh     = clamp_log2(pat_i.log2_res_h);
    lv     = clamp_log2(pat_i.log2_res_v);
    mask_h = (ext_t'(1) << lh) - ext_t'(1);
    mask_v = (ext_t'(1) << lv) - ext_t'(1);

    rx = (hc - x + sh) & mask_h;
    ry = (vc - y) & mask_v;
    if (spr_i.hflip) rx = mask_h - rx;
    if (spr_i.vflip) ry = mask_v - ry;

    addr_o = pat_i.append + (SCAN_ADDR_W'(ry) << lh) + SCAN_ADDR_W'(rx);
  end

endmodule

// File: rtl/sprite_addr_scan.sv
// Priority scan over NUM_SPRITES descriptors returning the first visible hit.
module sprite_addr_scan
  import sprite_scan_pkg::*;
#(
  parameter int NUM_SPRITES = 8,
  parameter int ADDR_W      = SCAN_ADDR_W,
  parameter int COORD_W     = SCAN_COORD_W
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic [NUM_SPRITES*(3+3*COORD_W)-1:0]     sprite_info,
  input  logic [NUM_SPRITES*(ADDR_W+8+2*COORD_W)-1:0] pattern_info,
  input  logic                                     req_valid,
  output logic                                     req_ready,
  input  logic [COORD_W-1:0]                       hcount,
  input  logic [COORD_W-1:0]                       vcount,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [ADDR_W-1:0]                        addr_out,
  output logic                                     hit,
  output logic [$clog2(NUM_SPRITES)-1:0]           sprite_id
);

  localparam int                IDX_W    = $clog2(NUM_SPRITES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_SPRITES - 1);

  sprite_t  spr_arr [NUM_SPRITES];
  pattern_t pat_arr [NUM_SPRITES];

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_unpack
    assign spr_arr[g] = sprite_t'(sprite_info[g*SPR_W +: SPR_W]);
    assign pat_arr[g] = pattern_t'(pattern_info[g*PAT_W +: PAT_W]);
  end

  scan_state_t        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [COORD_W-1:0] hc_q, hc_d, vc_q, vc_d;
  // Registered evaluation of sprite evi_q; the decision is taken one cycle later.
  logic               evv_q, evv_d, evh_q, evh_d;
  logic [ADDR_W-1:0]  eva_q, eva_d;
  logic [IDX_W-1:0]   evi_q, evi_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               hit_q, hit_d;
  logic [IDX_W-1:0]   id_q, id_d;

  logic               ev_hit;
  logic [ADDR_W-1:0]  ev_addr;

  sprite_hit_eval u_eval (
    .spr_i    (spr_arr[idx_q]),
    .pat_i    (pat_arr[idx_q]),
    .hcount_i (hc_q),
    .vcount_i (vc_q),
    .hit_o    (ev_hit),
    .addr_o   (ev_addr)
  );

  assign req_ready = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign addr_out  = addr_q;
  assign hit       = hit_q;
  assign sprite_id = id_q;

  // Next-state: accept in IDLE, walk the index in SCAN, hold results in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hc_d    = hc_q;
    vc_d    = vc_q;
    evv_d   = evv_q;
    evh_d   = evh_q;
    eva_d   = eva_q;
    evi_d   = evi_q;
    addr_d  = addr_q;
    hit_d   = hit_q;
    id_d    = id_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          hc_d    = hcount;
          vc_d    = vcount;
          idx_d   = '0;
          evv_d   = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        evv_d = 1'b1;
        evh_d = ev_hit;
        eva_d = ev_addr;
        evi_d = idx_q;
        if (idx_q != LAST_IDX) idx_d = idx_q + IDX_W'(1);
        if (evv_q && evh_q) begin
          addr_d  = eva_q;
          hit_d   = 1'b1;
          id_d    = evi_q;
          evv_d   = 1'b0;
          state_d = DONE;
        end else if (evv_q && (evi_q == LAST_IDX)) begin
          addr_d  = '0;
          hit_d   = 1'b0;
          id_d    = '0;
          evv_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any request in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hc_q    <= '0;
      vc_q    <= '0;
      evv_q   <= 1'b0;
      evh_q   <= 1'b0;
      eva_q   <= '0;
      evi_q   <= '0;
      addr_q  <= '0;
      hit_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      evv_q   <= evv_d;
      evh_q   <= evh_d;
      eva_q   <= eva_d;
      evi_q   <= evi_d;
      addr_q  <= addr_d;
      hit_q   <= hit_d;
      id_q    <= id_d;
    end
  end

endmodule

// File: tb/tb_sprite_addr_scan.sv
// Scoreboard bench for sprite_addr_scan: reference model predicts each request.
module tb_sprite_addr_scan;
  import sprite_scan_pkg::*;

  localparam int N  = 8;
  localparam int AW = 16;
  localparam int CW = 10;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N*SPR_W-1:0] sprite_info;
  logic [N*PAT_W-1:0] pattern_info;
  logic              req_valid, req_ready, out_valid, out_ready;
  logic [CW-1:0]     hcount, vcount;
  logic [AW-1:0]     addr_out;
  logic              hit;
  logic [2:0]        sprite_id;

  always #5 clk = ~clk;

  sprite_addr_scan #(.NUM_SPRITES(N), .ADDR_W(AW), .COORD_W(CW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sprite_info  (sprite_info),
    .pattern_info (pattern_info),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .hcount       (hcount),
    .vcount       (vcount),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .addr_out     (addr_out),
    .hit          (hit),
    .sprite_id    (sprite_id)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  int d_vis[N], d_hf[N], d_vf[N], d_x[N], d_y[N], d_sh[N];
  int d_app[N], d_lrh[N], d_lrv[N], d_ah[N], d_av[N];

  typedef struct {
    int hit;
    int addr;
    int id;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   last_addr, last_hit, last_id, last_lat;

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      d_vis[i] = 0; d_hf[i] = 0; d_vf[i] = 0; d_x[i] = 0; d_y[i] = 0; d_sh[i] = 0;
      d_app[i] = 0; d_lrh[i] = 0; d_lrv[i] = 0; d_ah[i] = 0; d_av[i] = 0;
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      sprite_info[i*SPR_W + SPR_VISIBLE_BIT]        = (d_vis[i] != 0);
      sprite_info[i*SPR_W + SPR_HFLIP_BIT]          = (d_hf[i] != 0);
      sprite_info[i*SPR_W + SPR_VFLIP_BIT]          = (d_vf[i] != 0);
      sprite_info[i*SPR_W + SPR_X_LSB +: CW]        = CW'(d_x[i]);
      sprite_info[i*SPR_W + SPR_Y_LSB +: CW]        = CW'(d_y[i]);
      sprite_info[i*SPR_W + SPR_SHIFT_LSB +: CW]    = CW'(d_sh[i]);
      pattern_info[i*PAT_W + PAT_APPEND_LSB +: AW]  = AW'(d_app[i]);
      pattern_info[i*PAT_W + PAT_LOG2_H_LSB +: 4]   = 4'(d_lrh[i]);
      pattern_info[i*PAT_W + PAT_LOG2_V_LSB +: 4]   = 4'(d_lrv[i]);
      pattern_info[i*PAT_W + PAT_ACT_H_LSB +: CW]   = CW'(d_ah[i]);
      pattern_info[i*PAT_W + PAT_ACT_V_LSB +: CW]   = CW'(d_av[i]);
    end
  endtask

  // Reference: first visible sprite whose window holds the pixel, integer math.
  function automatic exp_t model(input int hc, input int vc);
    exp_t e;
    int   lh, lv, rx, ry;
    e = '{hit: 0, addr: 0, id: 0, lat: N + 1};
    for (int i = 0; i < N; i++) begin
      if (d_vis[i] != 0 && vc >= d_y[i] && vc < d_y[i] + d_av[i] &&
          hc >= d_x[i] && hc < d_x[i] + d_ah[i] - d_sh[i]) begin
        lh = (d_lrh[i] > 8) ? 8 : d_lrh[i];
        lv = (d_lrv[i] > 8) ? 8 : d_lrv[i];
        rx = (hc - d_x[i] + d_sh[i]) % (1 << lh);
        ry = (vc - d_y[i]) % (1 << lv);
        if (d_hf[i] != 0) rx = (1 << lh) - 1 - rx;
        if (d_vf[i] != 0) ry = (1 << lv) - 1 - ry;
        e.hit  = 1;
        e.addr = (d_app[i] + ry * (1 << lh) + rx) & 32'hFFFF;
        e.id   = i;
        e.lat  = 2 + i;
        return e;
      end
    end
    return e;
  endfunction

  // One request; hold > 0 keeps out_ready low for that many cycles after out_valid.
  task automatic run_req(input int hc, input int vc, input int hold, input string tag);
    exp_t e;
    int   lat;
    sb.push_back(model(hc, vc));
    @(negedge clk);
    out_ready = (hold == 0);
    hcount    = CW'(hc);
    vcount    = CW'(vc);
    req_valid = 1'b1;
    check({tag, ".req_ready"}, req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    e = sb.pop_front();
    check({tag, ".out_valid"}, out_valid, 1);
    check({tag, ".latency"}, lat, e.lat);
    check({tag, ".hit"}, hit, e.hit);
    check({tag, ".addr"}, addr_out, e.addr);
    check({tag, ".id"}, sprite_id, e.id);
    last_addr = int'(addr_out);
    last_hit  = int'(hit);
    last_id   = int'(sprite_id);
    last_lat  = lat;
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk);
        #1;
        check({tag, ".stall_valid"}, out_valid, 1);
        check({tag, ".stall_ready"}, req_ready, 0);
        check({tag, ".stall_addr"}, addr_out, e.addr);
        check({tag, ".stall_hit"}, hit, e.hit);
        check({tag, ".stall_id"}, sprite_id, e.id);
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, ".post_valid"}, out_valid, 0);
    check({tag, ".post_ready"}, req_ready, 1);
  endtask

  task automatic basic_setup(input int slot);
    clear_all();
    d_vis[slot] = 1; d_x[slot] = 100; d_y[slot] = 50; d_sh[slot] = 0;
    d_ah[slot] = 16; d_av[slot] = 16; d_lrh[slot] = 4; d_lrv[slot] = 4;
    d_app[slot] = 'h0400;
  endtask

  initial begin
    reset_n      = 1'b0;
    req_valid    = 1'b0;
    out_ready    = 1'b1;
    hcount       = '0;
    vcount       = '0;
    sprite_info  = '0;
    pattern_info = '0;
    clear_all();
    apply();
    #12;
    check("reset.req_ready", req_ready, 1);
    check("reset.out_valid", out_valid, 0);
    check("reset.addr", addr_out, 0);
    check("reset.hit", hit, 0);
    check("reset.id", sprite_id, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic hit and the three flip combinations.
    basic_setup(0); apply();
    run_req(105, 53, 0, "basic");
    check("basic.addr_const", last_addr, 'h0435);
    check("basic.lat_const", last_lat, 2);
    d_hf[0] = 1; apply();
    run_req(105, 53, 0, "hflip");
    check("hflip.addr_const", last_addr, 'h043A);
    d_hf[0] = 0; d_vf[0] = 1; apply();
    run_req(105, 53, 0, "vflip");
    check("vflip.addr_const", last_addr, 'h04C5);
    d_hf[0] = 1; apply();
    run_req(105, 53, 0, "hvflip");
    check("hvflip.addr_const", last_addr, 'h04CA);

    // Priority: invisible 0/1 cover the pixel, 2 beats 5.
    clear_all();
    d_x[0] = 195; d_y[0] = 95; d_ah[0] = 16; d_av[0] = 16; d_lrh[0] = 4; d_lrv[0] = 4;
    d_x[1] = 198; d_y[1] = 98; d_ah[1] = 16; d_av[1] = 16; d_lrh[1] = 4; d_lrv[1] = 4;
    d_vis[2] = 1; d_hf[2] = 1; d_x[2] = 190; d_y[2] = 90; d_ah[2] = 16; d_av[2] = 32;
    d_lrh[2] = 5; d_lrv[2] = 5; d_app[2] = 'h1000;
    d_vis[5] = 1; d_x[5] = 195; d_y[5] = 95; d_ah[5] = 8; d_av[5] = 8;
    d_lrh[5] = 3; d_lrv[5] = 3; d_app[5] = 'h2000;
    apply();
    run_req(200, 100, 0, "prio");
    check("prio.id_const", last_id, 2);
    check("prio.lat_const", last_lat, 4);
    check("prio.addr_const", last_addr, 'h1155);

    // Full miss: everything invisible.
    d_vis[2] = 0; d_vis[5] = 0; apply();
    run_req(200, 100, 0, "miss");
    check("miss.hit_const", last_hit, 0);
    check("miss.lat_const", last_lat, 9);

    // Shift boundary.
    clear_all();
    d_vis[0] = 1; d_x[0] = 0; d_y[0] = 0; d_ah[0] = 32; d_av[0] = 16; d_sh[0] = 8;
    d_lrh[0] = 4; d_lrv[0] = 4; d_app[0] = 'h0200;
    apply();
    run_req(23, 2, 0, "shift_in");
    check("shift_in.addr_const", last_addr, 'h022F);
    run_req(24, 2, 0, "shift_out");
    check("shift_out.hit_const", last_hit, 0);
    d_ah[0] = 8; apply();
    run_req(0, 2, 0, "shift_empty");
    check("shift_empty.hit_const", last_hit, 0);

    // Backpressure on the basic setup.
    basic_setup(0); apply();
    run_req(110, 60, 5, "stall");

    // Randomised descriptors, including log2 values above 8.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        d_vis[i] = $urandom_range(0, 1); d_hf[i] = $urandom_range(0, 1);
        d_vf[i]  = $urandom_range(0, 1);
        d_x[i]   = $urandom_range(0, 60); d_y[i] = $urandom_range(0, 60);
        d_sh[i]  = $urandom_range(0, 20);
        d_ah[i]  = $urandom_range(0, 40); d_av[i] = $urandom_range(0, 40);
        d_lrh[i] = $urandom_range(0, 15); d_lrv[i] = $urandom_range(0, 15);
        d_app[i] = $urandom_range(0, 'hFFFF);
      end
      apply();
      run_req($urandom_range(0, 80), $urandom_range(0, 80), 0, $sformatf("rand%0d", r));
    end

    // Reset during SCAN at index 3 aborts the request.
    basic_setup(7); apply();
    @(negedge clk);
    hcount = CW'(105); vcount = CW'(53); req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort.out_valid", out_valid, 0);
    check("abort.addr", addr_out, 0);
    check("abort.hit", hit, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort.req_ready", req_ready, 1);
    check("abort.no_output", out_valid, 0);
    run_req(105, 53, 0, "after_reset");
    check("after_reset.addr_const", last_addr, 'h0435);
    check("after_reset.id_const", last_id, 7);

    check("scoreboard.empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
